// File: rtl/sev_seg_pkg.sv
// Shared constants for the 7-segment scan driver: the high-true hex glyph
// table, the blank pattern and the output polarity helper.
package sev_seg_pkg;

    // All segments dark, expressed high-true (gfedcba)
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Standard hex glyphs, high-true, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b0111111;
    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] GLYPH_7 = 7'b0000111;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1101111;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b1111100;
    localparam logic [6:0] GLYPH_C = 7'b0111001;
    localparam logic [6:0] GLYPH_D = 7'b1011110;
    localparam logic [6:0] GLYPH_E = 7'b1111001;
    localparam logic [6:0] GLYPH_F = 7'b1110001;

    // Packed lookup table, entry n is the glyph for nibble n
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    // Converts a high-true segment pattern to the pin polarity of the board
    function automatic logic [6:0] apply_pol(input logic [6:0] x, input logic active_low);
        return active_low ? ~x : x;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to high-true 7-segment glyph decoder.
module seg_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        glyph = HEX_GLYPHS[nibble];
    end

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed driver for a bank of common-anode 7-segment displays.
// A new value is loaded into a pending register at any time and only copied
// to the displayed register at the end of a full scan, so a frame never mixes
// digits from two different values.
module sev_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    import sev_seg_pkg::*;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    blank_mode;
    logic                    tick;
    logic                    swap;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              glyph;

    assign tick = (prescaler == PRE_LAST);
    assign swap = tick && (idx == IDX_LAST);

    // Slot timer: one full count is one digit's on-time
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit index advances once per slot and wraps after the leftmost digit
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Pending register holds the most recent load until the next frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
        end
    end

    // Displayed register changes only between frames so a scan is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            act_value  <= '0;
            act_dp     <= '0;
            blank_mode <= 1'b0;
        end else if (swap) begin
            act_value  <= pend_value;
            act_dp     <= pend_dp;
            blank_mode <= blank_lz;
        end
    end

    // Leading-zero mask built from the leftmost digit down; digit 0 always shows
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (act_value[4*i +: 4] == 4'h0);
            lz_mask[i] = (i != 0) && blank_mode && zero_above;
        end
    end

    // Select the nibble, decimal point, blank flag and anode for the current digit
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        onehot     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_nibble = act_value[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = lz_mask[i];
                onehot[i]  = 1'b1;
            end
        end
    end

    seg_decode u_decode (
        .nibble (cur_nibble),
        .glyph  (glyph)
    );

    // Registered pin drivers, so the pins never glitch while the mux settles
    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= apply_pol(SEG_OFF, POL);
            dp_out <= POL;
            an     <= {NUM_DIGITS{POL}};
            frame  <= 1'b0;
        end else begin
            seg    <= apply_pol(cur_blank ? SEG_OFF : glyph, POL);
            dp_out <= POL ^ (cur_dp && !cur_blank);
            an     <= {NUM_DIGITS{POL}} ^ onehot;
            frame  <= swap;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Self-checking bench for sev_seg_scan with 4 digits, 4-cycle slots, active-low pins.
// A time-based reference model predicts every registered output from the number
// of clock edges since reset and the history of loads.
module tb_sev_seg_scan;

    localparam int NUM = 4;
    localparam int DIV = 4;
    localparam int FRAME_LEN = NUM * DIV;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame;

    int checks;
    int errors;

    logic [6:0] hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int unsigned edge_cnt;
    logic [15:0] m_pend_val;
    logic [3:0]  m_pend_dp;
    logic [15:0] m_act_val;
    logic [3:0]  m_act_dp;
    logic        m_blank;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_frame;

    sev_seg_scan #(
        .NUM_DIGITS  (NUM),
        .REFRESH_DIV (DIV),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dp       (dp),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp_out   (dp_out),
        .an       (an),
        .frame    (frame)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: digit shown and frame boundaries follow directly from edge count
    always @(posedge clk) begin
        int d;
        logic [15:0] upper;
        logic blanked;
        if (rst) begin
            edge_cnt   = 0;
            m_pend_val = '0;
            m_pend_dp  = '0;
            m_act_val  = '0;
            m_act_dp   = '0;
            m_blank    = 1'b0;
            exp_seg    = 7'h7F;
            exp_dp     = 1'b1;
            exp_an     = 4'hF;
            exp_frame  = 1'b0;
        end else begin
            d         = (edge_cnt / DIV) % NUM;
            upper     = m_act_val >> (4 * d);
            blanked   = (d != 0) && m_blank && (upper == 16'h0);
            exp_seg   = blanked ? 7'h7F : ~hex_ref[upper[3:0]];
            exp_dp    = blanked ? 1'b1 : ~m_act_dp[d];
            exp_an    = ~(4'b0001 << d);
            exp_frame = ((edge_cnt % FRAME_LEN) == FRAME_LEN - 1);
            if (exp_frame) begin
                m_act_val = m_pend_val;
                m_act_dp  = m_pend_dp;
                m_blank   = blank_lz;
            end
            if (load) begin
                m_pend_val = value;
                m_pend_dp  = dp;
            end
            edge_cnt = edge_cnt + 1;
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME_LEN && !seen; i++) begin
            @(negedge clk);
            if (frame === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_frame_wait: frame got 0 for %0d cycles, expected a pulse", name, 3 * FRAME_LEN);
        end
    endtask

    task automatic load_value(input logic [15:0] v, input logic [3:0] p);
        value = v;
        dp    = p;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F || an !== 4'hF || dp_out !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got seg=%h an=%h dp=%b frame=%b, expected seg=7f an=f dp=1 frame=0",
                     seg, an, dp_out, frame);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reset_first_digit: an got %b expected 1110", an);
        end
        repeat (DIV) @(negedge clk);
        checks++;
        if (an !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL reset_second_digit: an got %b expected 1101", an);
        end
        repeat (FRAME_LEN - DIV) @(negedge clk);
        checks++;
        if (an !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reset_rotation: an got %b expected 1110 after 16 cycles", an);
        end
    endtask

    task automatic test_digits();
        logic [6:0] want [4];
        want[0] = ~7'b1110001;
        want[1] = ~7'b1110111;
        want[2] = ~7'b1011011;
        want[3] = ~7'b0000110;
        blank_lz = 1'b0;
        load_value(16'h12AF, 4'b0100);
        wait_frame("digits");
        @(negedge clk);
        for (int d = 0; d < NUM; d++) begin
            checks++;
            if (an !== ~(4'b0001 << d) || seg !== want[d] || dp_out !== (d == 2 ? 1'b0 : 1'b1)) begin
                errors++;
                $display("[TB] FAIL digits_d%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         d, an, seg, dp_out, ~(4'b0001 << d), want[d], (d == 2 ? 1'b0 : 1'b1));
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_blanking();
        logic [6:0] want [4];
        want[0] = ~7'b0111111;
        want[1] = ~7'b1100110;
        want[2] = 7'h7F;
        want[3] = 7'h7F;
        blank_lz = 1'b1;
        load_value(16'h0000, 4'b1100);
        load_value(16'h0040, 4'b1100);
        wait_frame("blank");
        @(negedge clk);
        for (int d = 0; d < NUM; d++) begin
            checks++;
            if (an !== ~(4'b0001 << d) || seg !== want[d] || dp_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL blank_d%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=1",
                         d, an, seg, dp_out, ~(4'b0001 << d), want[d]);
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_swap_collision();
        logic [6:0] old_want [4];
        old_want[0] = ~7'b0111111;
        old_want[1] = ~7'b1100110;
        old_want[2] = 7'h7F;
        old_want[3] = 7'h7F;
        wait_frame("collide");
        repeat (FRAME_LEN - 1) @(negedge clk);
        load_value(16'h1111, 4'b0000);
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_frame: frame got %b expected 1 on load edge", frame);
        end
        @(negedge clk);
        for (int d = 0; d < NUM; d++) begin
            checks++;
            if (seg !== old_want[d]) begin
                errors++;
                $display("[TB] FAIL collide_old_d%0d: seg got %h expected %h", d, seg, old_want[d]);
            end
            repeat (DIV) @(negedge clk);
        end
        for (int d = 0; d < NUM; d++) begin
            checks++;
            if (seg !== ~7'b0000110 || an !== ~(4'b0001 << d)) begin
                errors++;
                $display("[TB] FAIL collide_new_d%0d: got seg=%h an=%b expected seg=79 an=%b",
                         d, seg, an, ~(4'b0001 << d));
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_LEN && !found; i++) begin
            @(negedge clk);
            if (an === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL midrst_find_slot2: an never got 1011");
        end
        @(negedge clk);
        blank_lz = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (seg !== 7'h7F || an !== 4'hF || dp_out !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_off: got seg=%h an=%h dp=%b frame=%b, expected 7f f 1 0",
                     seg, an, dp_out, frame);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NUM; d++) begin
            checks++;
            if (seg !== ~7'b0111111 || an !== ~(4'b0001 << d) || dp_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL midrst_zero_d%0d: got seg=%h an=%b dp=%b expected seg=40 an=%b dp=1",
                         d, seg, an, dp_out, ~(4'b0001 << d));
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic test_random();
        int last_frame;
        int frames;
        last_frame = -1;
        frames = 0;
        for (int c = 0; c < 1000; c++) begin
            load     = ($urandom_range(0, 3) == 0);
            value    = 16'($urandom);
            dp       = 4'($urandom);
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            @(negedge clk);
            checks++;
            if (seg !== exp_seg || dp_out !== exp_dp || an !== exp_an || frame !== exp_frame) begin
                errors++;
                $display("[TB] FAIL random_c%0d: got seg=%h dp=%b an=%b frame=%b expected seg=%h dp=%b an=%b frame=%b",
                         c, seg, dp_out, an, frame, exp_seg, exp_dp, exp_an, exp_frame);
            end
            checks++;
            if ($countones(~an) != 1) begin
                errors++;
                $display("[TB] FAIL random_onehot_c%0d: an got %b expected exactly one low bit", c, an);
            end
            if (frame === 1'b1) begin
                if (last_frame >= 0) begin
                    checks++;
                    if (c - last_frame != FRAME_LEN) begin
                        errors++;
                        $display("[TB] FAIL random_frame_period: got %0d cycles expected %0d",
                                 c - last_frame, FRAME_LEN);
                    end
                end
                last_frame = c;
                frames++;
            end
        end
        load = 1'b0;
        checks++;
        if (frames < 1000 / FRAME_LEN) begin
            errors++;
            $display("[TB] FAIL random_frame_count: got %0d frames expected at least %0d",
                     frames, 1000 / FRAME_LEN);
        end
    endtask

    // Scenario sequence
    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        value    = '0;
        dp       = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        test_reset();
        test_digits();
        test_blanking();
        test_swap_collision();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
